// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared widths and the writeback request record for the
//               register-file writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Which requester wins the next conflict.
    typedef enum logic [0:0] {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; req[0]=ALU, req[1]=LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import rv32_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_e r_prio;
    prio_e w_prio_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= PRIO_ALU;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Every grant is a transfer, so the pointer moves only when one happens.
    always_comb begin
        w_prio_next = r_prio;
        if (gnt[0]) begin
            w_prio_next = PRIO_LSU;
        end else if (gnt[1]) begin
            w_prio_next = PRIO_ALU;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_prio == PRIO_ALU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates ALU/LSU writebacks onto one register-file write
//               port and keeps a pending-write scoreboard. Defining
//               REGFILE_WB_BYPASS_EN adds write-port bypass outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr_w,
    output logic [XLEN-1:0]       rf_data_w,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [NUM_REGS-1:0]   busy
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                  byp_rs1_hit,
    output logic [XLEN-1:0]       byp_rs1_data,
    output logic                  byp_rs2_hit,
    output logic [XLEN-1:0]       byp_rs2_data
`endif
);

    logic [1:0]            w_gnt;
    wb_req_t               w_sel;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic                  w_rs1_pend;
    logic                  w_rs2_pend;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({lsu_valid, alu_valid}),
        .gnt     (w_gnt)
    );

    assign alu_ready = w_gnt[0];
    assign lsu_ready = w_gnt[1];

    always_comb begin
        w_sel = '0;
        if (w_gnt[0]) begin
            w_sel.valid = 1'b1;
            w_sel.rd    = alu_rd;
            w_sel.data  = alu_data;
        end else if (w_gnt[1]) begin
            w_sel.valid = 1'b1;
            w_sel.rd    = lsu_rd;
            w_sel.data  = lsu_data;
        end
    end

    // x0 writebacks complete the handshake but never reach the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_sel.valid && (w_sel.rd != '0)) begin
            r_we   <= 1'b1;
            r_addr <= w_sel.rd;
            r_data <= w_sel.data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign rf_we     = r_we;
    assign rf_addr_w = r_addr;
    assign rf_data_w = r_data;

    assign w_set = (issue_valid && (issue_rd != '0)) ? (NUM_REGS'(1) << issue_rd) : '0;
    assign w_clr = r_we ? (NUM_REGS'(1) << r_addr) : '0;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
        end
    end

    assign busy       = r_busy;
    assign w_rs1_pend = r_busy[rs1_addr];
    assign w_rs2_pend = r_busy[rs2_addr];

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_rs1_hit  = r_we && (r_addr == rs1_addr) && (rs1_addr != '0);
    assign byp_rs2_hit  = r_we && (r_addr == rs2_addr) && (rs2_addr != '0);
    assign byp_rs1_data = r_data;
    assign byp_rs2_data = r_data;
    assign rs1_busy     = w_rs1_pend && !byp_rs1_hit;
    assign rs2_busy     = w_rs2_pend && !byp_rs2_hit;
`else
    assign rs1_busy     = w_rs1_pend;
    assign rs2_busy     = w_rs2_pend;
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic        byp_rs1_hit;
    logic [31:0] byp_rs1_data;
    logic        byp_rs2_hit;
    logic [31:0] byp_rs2_data;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .rf_we       (rf_we),
        .rf_addr_w   (rf_addr_w),
        .rf_data_w   (rf_data_w),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy        (busy)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs1_data (byp_rs1_data),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_rs2_data (byp_rs2_data)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1ns later.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1_addr = '0; rs2_addr = '0;

        // Reset state, with a request held to prove ready stays low.
        next_cyc();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check_val("rst_rf_we",     rf_we,     0);
        check_val("rst_rf_addr",   rf_addr_w, 0);
        check_val("rst_rf_data",   rf_data_w, 0);
        check_val("rst_busy",      busy,      0);
        check_val("rst_alu_ready", alu_ready, 0);
        check_val("rst_lsu_ready", lsu_ready, 0);
        next_cyc();

        // First cycle after release: ALU-only writeback rd=5.
        reset_n = 1'b1;
        #1;
        check_val("alu_only_ready", alu_ready, 1);
        check_val("alu_only_lsu_rdy", lsu_ready, 0);
        next_cyc();
        alu_valid = 1'b0;
        #1;
        check_val("alu_only_we",   rf_we,     1);
        check_val("alu_only_addr", rf_addr_w, 5);
        check_val("alu_only_data", rf_data_w, 32'hDEADBEEF);
        next_cyc();
        #1;
        check_val("idle_we", rf_we, 0);

        // Sole LSU requester; leaves pointer favouring ALU.
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h55;
        #1;
        check_val("lsu_only_ready", lsu_ready, 1);
        check_val("lsu_only_alu_rdy", alu_ready, 0);
        next_cyc();
        lsu_valid = 1'b0;
        #1;
        check_val("lsu_only_addr", rf_addr_w, 3);
        check_val("lsu_only_data", rf_data_w, 32'h55);

        // Four-cycle conflict: grants alternate ALU, LSU, ALU, LSU.
        next_cyc();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k > 0) begin
                check_val($sformatf("rr_addr_%0d", k-1), rf_addr_w, ((k-1) % 2 == 0) ? 1 : 2);
                check_val($sformatf("rr_data_%0d", k-1), rf_data_w, ((k-1) % 2 == 0) ? 32'hA1 : 32'hB2);
            end
            if (k < 4) begin
                check_val($sformatf("rr_alu_rdy_%0d", k), alu_ready, (k % 2 == 0) ? 1 : 0);
                check_val($sformatf("rr_lsu_rdy_%0d", k), lsu_ready, (k % 2 == 0) ? 0 : 1);
            end
            next_cyc();
            if (k == 3) begin
                alu_valid = 1'b0; lsu_valid = 1'b0;
            end
        end

        // Scoreboard: issue rd=7, then ALU writeback clears it.
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        #1;
        check_val("sb_pre_busy", rs1_busy, 0);
        next_cyc();
        issue_valid = 1'b0;
        #1;
        check_val("sb_set_vec", busy, 32'h80);
        check_val("sb_set_rs1", rs1_busy, 1);
        next_cyc();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        #1;
        check_val("sb_wb_ready", alu_ready, 1);
        check_val("sb_wb_rs1",   rs1_busy, 1);
        next_cyc();
        alu_valid = 1'b0;
        #1;
        check_val("sb_we_cycle", rf_we, 1);
        check_val("sb_we_rs1",   rs1_busy, 1);
        next_cyc();
        #1;
        check_val("sb_clr_vec", busy, 0);
        check_val("sb_clr_rs1", rs1_busy, 0);

        // Same-cycle set and clear on rd=9: set wins.
        issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd9;
        next_cyc();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        next_cyc();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        check_val("sw_we", rf_we, 1);
`ifdef REGFILE_WB_BYPASS_EN
        check_val("byp_rs2_hit",  byp_rs2_hit,  1);
        check_val("byp_rs2_data", byp_rs2_data, 32'h1234);
        check_val("byp_rs2_busy", rs2_busy,     0);
        check_val("byp_rs1_hit",  byp_rs1_hit,  0);
`else
        check_val("nobyp_rs2_busy", rs2_busy, 1);
`endif
        next_cyc();
        issue_valid = 1'b0;
        #1;
        check_val("sw_busy", busy, 32'h200);
        check_val("sw_rs2",  rs2_busy, 1);
        // Drain rd=9 so the scoreboard is clean again.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        next_cyc();
        alu_valid = 1'b0;
        next_cyc();
        #1;
        check_val("sw_drain", busy, 0);

        // Writeback and issue to x0.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        #1;
        check_val("x0_ready", alu_ready, 1);
        next_cyc();
        alu_valid = 1'b0; issue_valid = 1'b0;
        #1;
        check_val("x0_no_we", rf_we, 0);
        check_val("x0_busy",  busy,  0);
        check_val("x0_rs1",   rs1_busy, 0);

        // Reset mid-operation with busy=0x80 and pointer favouring LSU.
        issue_valid = 1'b1; issue_rd = 5'd7;
        next_cyc();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
        #1;
        check_val("mr_busy_pre", busy, 32'h80);
        check_val("mr_lsu_rdy",  lsu_ready, 1);
        reset_n = 1'b0;
        #1;
        check_val("mr_rst_alu_rdy", alu_ready, 0);
        check_val("mr_rst_lsu_rdy", lsu_ready, 0);
        check_val("mr_rst_busy",    busy, 0);
        next_cyc();
        #1;
        check_val("mr_no_we", rf_we, 0);
        reset_n = 1'b1;
        #1;
        check_val("mr_post_alu_rdy", alu_ready, 1);
        check_val("mr_post_lsu_rdy", lsu_ready, 0);
        next_cyc();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check_val("mr_post_addr", rf_addr_w, 1);
        check_val("mr_post_we",   rf_we, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
- REQ-001 SHALL have one clock; reset is asynchronous and active-low.
- REQ-002 SHALL take parameter XLEN, default 32, meaning the data width of the register file write port.
- REQ-003 SHALL have these ports, in order:
  - clk  in  1  clock, rising edge.
  - reset_n  in  1  asynchronous active-low reset.
  - issue_valid  in  1  an instruction is issued that will write issue_rd.
  - issue_rd  in  5  destination register of the issued instruction.
  - alu_valid / alu_ready  in / out  1 each  ALU writeback handshake.
  - alu_rd / alu_data  in  5 / XLEN  ALU writeback destination and value.
  - lsu_valid / lsu_ready  in / out  1 each  load-unit writeback handshake.
  - lsu_rd / lsu_data  in  5 / XLEN  load writeback destination and value.
  - rf_we / rf_addr_w / rf_data_w  out  1 / 5 / XLEN  registered drive of the register file write port.
  - rs1_addr / rs2_addr  in  5 each  decode-stage read addresses.
  - rs1_busy / rs2_busy  out  1 each  the read register has a pending write.
  - busy  out  32  scoreboard vector.

Function
- REQ-004 SHALL make a transfer on a requester in cycle N when its valid and ready are both 1.
- REQ-005 SHALL assert at most one ready per cycle; ready SHALL be combinational from both valids and the priority pointer.
- REQ-006 SHALL grant the sole requester when only one valid is 1.
- REQ-007 SHALL grant the requester not granted most recently when both valids are 1; the first conflict after reset goes to ALU.
- REQ-008 SHALL update the priority pointer only on a transfer.
- REQ-009 SHALL drive rf_we=1 in cycle N+1 for a transfer in cycle N, with the registered rd and data (1-cycle latency).
- REQ-010 SHALL drive rf_we=0 in any cycle with no transfer in the previous cycle.
- REQ-011 SHALL accept a transfer to rd=0 (ready asserted), produce no rf_we, and leave the scoreboard unchanged.
- REQ-012 SHALL set busy[issue_rd] on the edge ending a cycle with issue_valid=1 and issue_rd!=0.
- REQ-013 SHALL clear busy[rf_addr_w] on the edge ending a cycle with rf_we=1.
- REQ-014 SHALL let set win when set and clear hit the same register in the same cycle.
- REQ-015 SHALL hold busy[0] at 0 permanently.
- REQ-016 SHALL compute rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr] combinationally; both SHALL be 0 for address 0.
- REQ-017 SHALL ignore a valid held without ready; there is no data loss because the requester holds its payload.

Reset
- REQ-018 SHALL, while reset_n=0: rf_we=0, rf_addr_w=0, rf_data_w=0, busy=0, pointer=ALU, alu_ready=0, lsu_ready=0.
- REQ-019 SHALL discard a transfer granted in the cycle reset asserts; no rf_we follows it.
- REQ-020 SHALL be able to grant in the first cycle after reset_n rises.

Configuration
- REQ-021 With REGFILE_WB_BYPASS_EN defined, SHALL add outputs byp_rs1_hit, byp_rs1_data, byp_rs2_hit and byp_rs2_data.
  - byp_rsX_hit = rf_we && rf_addr_w==rsX_addr && rsX_addr!=0, and byp_rsX_data = rf_data_w.
  - rsX_busy SHALL be forced to 0 when byp_rsX_hit=1.
- REQ-022 Without REGFILE_WB_BYPASS_EN, those ports SHALL be absent and rsX_busy SHALL follow REQ-016 unmodified.

Structure
- REQ-023 SHALL take XLEN, REG_ADDR_W=5, NUM_REGS=32 and the struct wb_req_t {valid, rd, data} from shared package rv32_pkg.
- REQ-024 SHALL place the round-robin decision in sub-module rr_arbiter2, a 2-way arbiter with pointer register.

Verification
- REQ-025 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 3 -> alu_ready=1 in cycle 3; rf_we=1, addr=5, data=0xDEADBEEF in cycle 4.
- REQ-026 Both valid for 4 cycles, rd 1 (ALU) and 2 (LSU):
  - grants alternate ALU, LSU, ALU, LSU.
  - rf_addr_w sequence is 1, 2, 1, 2.
- REQ-027 Scoreboard:
  - issue rd=7 -> busy[7]=1 next cycle.
  - ALU writeback rd=7 -> busy[7]=0 on the edge after the rf_we cycle.
  - rs1_addr=7 reads busy=1 throughout.
- REQ-028 Writeback to rd=0 with data 0xFFFFFFFF -> ready=1, no rf_we; issue rd=0 -> busy stays 0.
- REQ-029 Reset mid-operation: assert reset_n=0 in the grant cycle, busy=0x0000_0080 -> rf_we=0, busy=0, next conflict granted to ALU.
- REQ-030 With REGFILE_WB_BYPASS_EN: rf_we=1, addr=9, data=0x1234 and rs2_addr=9 -> byp_rs2_hit=1, byp_rs2_data=0x1234, rs2_busy=0.
